// File: rtl/spi_master_9252.sv
// spi_master_9252 : 3-wire SPI frame engine for AD9252 register access.
// Latches a 24-bit frame {R/W,W1,W0,A12..A0,D7..D0} from adc_data[31:8] on start
// and shifts it MSB first: SDIO changes on SCLK fall and is stable across SCLK rise.
// Frame timing: SETUP (CLK_DIV) + 24 bits (2*CLK_DIV each) + HOLD (CLK_DIV) with CSB low,
// then GAP_CYC cycles with CSB high and busy still set, then one GAP cycle that
// carries the done pulse with busy already low.
// Optional feature macro: SPI_READBACK_EN adds SDIO turnaround and an 8-bit read capture.
module spi_master_9252 #(
    parameter int CLK_DIV = 4,   // SCLK half-period in clk cycles, 2..255
    parameter int GAP_CYC = 4    // CSB-high cycles before busy drops, 1..255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] adc_data,
    output logic        busy,
    output logic        done,
    output logic        spi_csb,
    output logic        spi_sclk,
    output logic        spi_sdio
`ifdef SPI_READBACK_EN
    ,
    output logic        spi_sdio_oe,
    input  logic        spi_sdi,
    output logic [7:0]  rd_data,
    output logic        rd_valid
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC);

    state_t      state, state_n;
    logic [7:0]  div_cnt, div_n;
    logic [4:0]  bit_cnt, bit_n;
    logic [23:0] shreg, shreg_n;
    logic        busy_n, done_n, csb_n, sclk_n;

    // The low byte of the command word carries no frame content.
    logic unused_low_byte;
    assign unused_low_byte = ^adc_data[7:0];

    // SDIO is the shift register MSB; clearing the register on GAP entry parks it low.
    assign spi_sdio = shreg[23];

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            bit_cnt  <= 5'd0;
            shreg    <= 24'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_csb  <= 1'b1;
            spi_sclk <= 1'b0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            busy     <= busy_n;
            done     <= done_n;
            spi_csb  <= csb_n;
            spi_sclk <= sclk_n;
        end
    end

    // Next-state and next-output logic; counters reload on every phase or state entry.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        busy_n  = busy;
        done_n  = 1'b0;
        csb_n   = spi_csb;
        sclk_n  = spi_sclk;

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                csb_n  = 1'b1;
                sclk_n = 1'b0;
                if (start) begin
                    shreg_n = adc_data[31:8];
                    csb_n   = 1'b0;
                    busy_n  = 1'b1;
                    div_n   = DIV_LOAD;
                    state_n = SETUP;
                end
            end

            // CSB-to-SCLK setup with SCLK held low.
            SETUP: begin
                if (div_cnt != 8'd0) begin
                    div_n = div_cnt - 8'd1;
                end else begin
                    div_n   = DIV_LOAD;
                    bit_n   = 5'd23;
                    state_n = SHIFT;
                end
            end

            // Each bit: low half-period then high half-period; advance data on the fall.
            SHIFT: begin
                if (div_cnt != 8'd0) begin
                    div_n = div_cnt - 8'd1;
                end else if (!spi_sclk) begin
                    sclk_n = 1'b1;
                    div_n  = DIV_LOAD;
                end else if (bit_cnt != 5'd0) begin
                    sclk_n  = 1'b0;
                    div_n   = DIV_LOAD;
                    bit_n   = bit_cnt - 5'd1;
                    shreg_n = {shreg[22:0], 1'b0};
                end else begin
                    sclk_n  = 1'b0;
                    div_n   = DIV_LOAD;
                    state_n = HOLD;
                end
            end

            // SCLK-to-CSB hold; the last bit stays on SDIO.
            HOLD: begin
                if (div_cnt != 8'd0) begin
                    div_n = div_cnt - 8'd1;
                end else begin
                    csb_n   = 1'b1;
                    shreg_n = 24'd0;
                    div_n   = GAP_LOAD;
                    state_n = GAP;
                end
            end

            // GAP_CYC busy cycles with CSB high, then one cycle carrying done.
            GAP: begin
                if (div_cnt == 8'd1) begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                    div_n  = 8'd0;
                end else if (div_cnt == 8'd0) begin
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt - 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                csb_n   = 1'b1;
                sclk_n  = 1'b0;
                shreg_n = 24'd0;
            end
        endcase
    end

`ifdef SPI_READBACK_EN
    logic       rw;
    logic [7:0] rd_shift;
    logic       accept_evt, rise_evt, fall_evt, hold_evt, done_evt;

    // Frame events decoded from the current state and counters.
    assign accept_evt = (state == IDLE)  && start;
    assign rise_evt   = (state == SHIFT) && (div_cnt == 8'd0) && !spi_sclk;
    assign fall_evt   = (state == SHIFT) && (div_cnt == 8'd0) && spi_sclk && (bit_cnt != 5'd0);
    assign hold_evt   = (state == SHIFT) && (div_cnt == 8'd0) && spi_sclk && (bit_cnt == 5'd0);
    assign done_evt   = (state == GAP)   && (div_cnt == 8'd1);

    // Read turnaround after the 16th fall, capture on rises 17..24, publish with done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rw          <= 1'b0;
            spi_sdio_oe <= 1'b1;
            rd_shift    <= 8'd0;
            rd_data     <= 8'd0;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid <= done_evt && rw;
            if (accept_evt) begin
                rw <= adc_data[31];
            end
            if (fall_evt && rw && (bit_cnt == 5'd8)) begin
                spi_sdio_oe <= 1'b0;
            end
            if (hold_evt) begin
                spi_sdio_oe <= 1'b1;
            end
            if (rise_evt && (bit_cnt < 5'd8)) begin
                rd_shift <= {rd_shift[6:0], spi_sdi};
            end
            if (done_evt && rw) begin
                rd_data <= rd_shift;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_9252.sv
// Bench for spi_master_9252: frame-offset reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_spi_master_9252;

    localparam int D    = 4;
    localparam int G    = 4;
    localparam int FR   = 50 * D;        // cycles with CSB low
    localparam int LAST = 50 * D + G + 1; // offset of the done cycle

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] adc_data = 32'd0;
    logic        busy, done, spi_csb, spi_sclk, spi_sdio;
    logic [7:0]  sdi_byte = 8'd0;
`ifdef SPI_READBACK_EN
    logic        spi_sdio_oe;
    logic        spi_sdi = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
`endif

    always #5 clk = ~clk;

    spi_master_9252 #(.CLK_DIV(D), .GAP_CYC(G)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .adc_data (adc_data),
        .busy     (busy),
        .done     (done),
        .spi_csb  (spi_csb),
        .spi_sclk (spi_sclk),
        .spi_sdio (spi_sdio)
`ifdef SPI_READBACK_EN
        ,
        .spi_sdio_oe (spi_sdio_oe),
        .spi_sdi     (spi_sdi),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: k is the offset within a frame (0 = idle).
    int          k = 0;
    logic [23:0] m_frame = 24'd0;
    logic [7:0]  m_byte = 8'd0;
    logic [7:0]  m_rd = 8'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k    = 0;
            m_rd = 8'd0;
        end else if (k == 0) begin
            if (start === 1'b1) begin
                k       = 1;
                m_frame = adc_data[31:8];
                m_byte  = sdi_byte;
            end
        end else if (k == LAST) begin
            k = 0;
        end else begin
            k++;
            if (k == LAST && m_frame[23]) m_rd = m_byte;
        end
    end

    // Expected {busy, done, csb, sclk, sdio} for frame offset kk.
    function automatic logic [4:0] exp_vec(input int kk, input logic [23:0] fr);
        logic b, d, c, s, o;
        int j, bi;
        b = 1'b0; d = 1'b0; c = 1'b1; s = 1'b0; o = 1'b0; bi = 0;
        if (kk >= 1 && kk <= FR) begin
            b = 1'b1;
            c = 1'b0;
            if (kk <= D) begin
                bi = 0;
            end else if (kk <= 49 * D) begin
                j  = kk - D - 1;
                bi = j / (2 * D);
                s  = (j % (2 * D)) >= D;
            end else begin
                bi = 23;
            end
            o = fr[23 - bi];
        end else if (kk > FR && kk < LAST) begin
            b = 1'b1;
        end else if (kk == LAST) begin
            d = 1'b1;
        end
        return {b, d, c, s, o};
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("outputs", {27'd0, busy, done, spi_csb, spi_sclk, spi_sdio},
              {27'd0, exp_vec(k, m_frame)});
`ifdef SPI_READBACK_EN
        check("readback",
              {22'd0, spi_sdio_oe, rd_valid, rd_data},
              {22'd0, !(m_frame[23] && k >= 33 * D + 1 && k <= 49 * D && reset_n),
               (k == LAST) && m_frame[23], m_rd});
`endif
    end

    // Observation monitors for the directed scenarios.
    logic [23:0] cap = 24'd0;
    int rises = 0, busy_cnt = 0, csb_cnt = 0, done_cnt = 0;
    always @(posedge spi_sclk) begin
        cap = {cap[22:0], spi_sdio};
        rises++;
    end
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (spi_csb === 1'b0) csb_cnt++;
        if (done === 1'b1) done_cnt++;
    end

`ifdef SPI_READBACK_EN
    int   rise_cnt = 0;
    int   oe_fall_k = -1;
    logic oe_prev = 1'b1;
    logic rdv_at_done = 1'b0;
    always @(negedge spi_csb) rise_cnt = 0;
    always @(posedge spi_sclk) rise_cnt++;
    // ADC side: drive the read byte after each fall, MSB first, for rises 17..24.
    always @(negedge spi_sclk) begin
        if (rise_cnt >= 16 && rise_cnt <= 23) spi_sdi = sdi_byte[23 - rise_cnt];
        else spi_sdi = 1'b0;
    end
    always @(negedge clk) begin
        if (oe_prev && !spi_sdio_oe) oe_fall_k = k;
        oe_prev = spi_sdio_oe;
        if (done === 1'b1) rdv_at_done = rd_valid;
    end
`endif

    task automatic clr_mon();
        cap = 24'd0; rises = 0; busy_cnt = 0; csb_cnt = 0; done_cnt = 0;
    endtask

    task automatic pulse(input logic [31:0] d);
        @(posedge clk); #1;
        adc_data = d;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and quiet idle.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {27'd0, busy, done, spi_csb, spi_sclk, spi_sdio}, 32'b00100);
        reset_n = 1'b1;
        clr_mon();
        repeat (1000) @(posedge clk);
        #1;
        check("idle_busy", busy_cnt, 0);
        check("idle_csb", csb_cnt, 0);
        check("idle_rises", rises, 0);

        // Single frame 000D0C.
        clr_mon();
        pulse(32'h000D0C0C);
        adc_data = 32'hFFFFFFFF;  // must not disturb the latched frame
        wait_done(400);
        repeat (3) @(posedge clk);
        #1;
        check("t2_frame", cap, 24'h000D0C);
        check("t2_busy_cycles", busy_cnt, 204);
        check("t2_done_cnt", done_cnt, 1);

        // Frame 00FF01.
        clr_mon();
        pulse(32'h00FF0101);
        wait_done(400);
        repeat (3) @(posedge clk);
        #1;
        check("t3_frame", cap, 24'h00FF01);
        check("t3_csb_low", csb_cnt, 200);
        check("t3_rises", rises, 24);

        // Starts while busy and on the done cycle are dropped.
        clr_mon();
        repeat (9) @(posedge clk);
        pulse(32'h00A55A00);
        repeat (38) @(posedge clk);
        pulse(32'h12345600);
        wait_done(400);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_start_on_done", {31'd0, busy}, 32'd0);
        check("t4_one_frame", done_cnt, 1);
        check("t4_first_frame", cap, 24'h00A55A);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_start_after_done", {31'd0, busy}, 32'd1);
        wait_done(400);
        repeat (3) @(posedge clk);
        #1;
        check("t4_second_frame", cap, 24'h123456);
        check("t4_done_cnt", done_cnt, 2);

        // Reset in the high phase of bit 12 aborts the frame.
        pulse(32'h00C33C00);
        for (int i = 0; i < 400 && k != D + 1 + 2 * D * 11 + D + 1; i++) begin
            @(posedge clk); #1;
        end
        check("t5_sclk_before", {31'd0, spi_sclk}, 32'd1);
        #2;
        reset_n = 1'b0;
        clr_mon();
        #1;
        check("t5_abort", {29'd0, spi_csb, spi_sclk, busy}, 32'b100);
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_done", done_cnt, 0);
        reset_n = 1'b1;
        clr_mon();
        pulse(32'h5A5A5A00);
        wait_done(400);
        repeat (3) @(posedge clk);
        #1;
        check("t5_clean_frame", cap, 24'h5A5A5A);
        check("t5_rises", rises, 24);
        check("t5_busy_cycles", busy_cnt, 204);

`ifdef SPI_READBACK_EN
        // Register read returning A5.
        sdi_byte = 8'hA5;
        pulse(32'h80010000);
        wait_done(400);
        repeat (3) @(posedge clk);
        #1;
        check("t6_rd_data", {24'd0, rd_data}, 32'hA5);
        check("t6_oe_fall", oe_fall_k, 33 * D + 1);
        check("t6_rdv_with_done", {31'd0, rdv_at_done}, 32'd1);
`endif

        // Randomized traffic: random data every cycle, sparse starts.
        for (int i = 0; i < 7000; i++) begin
            @(posedge clk); #1;
            adc_data = $urandom;
            start    = ($urandom_range(0, 39) == 0);
            if (spi_csb === 1'b1) sdi_byte = 8'($urandom);
        end
        start = 1'b0;
        repeat (LAST + 5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
